// File: rtl/unary_pkg.sv
// Shared defaults and FSM state type for the unary rate generator.
// Imported by the counter and the top level.
package unary_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = DATA_WIDTH_DEF - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/bitrev_cnt.sv
// Stream position counter with clear/load-zero/enable.
// o_rev is the bit-reversal of the value the counter takes next.
module bitrev_cnt
  import unary_pkg::*;
#(
  parameter int W = CNT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         ld0,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_rev
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || ld0) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_comb begin
    o_rev = '0;
    for (int b = 0; b < W; b++) begin
      o_rev[b] = cnt_d[W-1-b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/unary_rate_gen.sv
// Signed operand to rate-coded unary bitstream generator.
// Streams 2^CNT_WIDTH bits whose one-count equals the saturated magnitude.
module unary_rate_gen
  import unary_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = DATA_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_data_sign,
  output logic                  o_data_dff,
  output logic                  o_busy,
  output logic                  o_last
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam int AW =
    (DATA_WIDTH > CNT_WIDTH) ? DATA_WIDTH : CNT_WIDTH;

  state_e state_q, state_d;
  logic sign_q, sign_d;
  logic [CNT_WIDTH-1:0] mag_q, mag_d;
  logic dff_q, dff_d;
  logic osign_q, osign_d;
  logic busy_q, busy_d;
  logic last_q, last_d;
  logic alive_q;

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] rev_d;
  logic cnt_en, cnt_clr, cnt_ld0;

  logic at_end, ready, accept, adv, fin, neg;
  logic [DATA_WIDTH-1:0] abs_v;
  logic [AW-1:0] abs_w;
  logic [CNT_WIDTH-1:0] sat;

  bitrev_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .ld0   (cnt_ld0),
    .o_cnt (cnt),
    .o_rev (rev_d)
  );

  assign at_end = (cnt == CNT_MAX);
  assign ready  = alive_q & ~clr &
                  ((state_q == IDLE) | (at_end & en));
  assign accept = i_valid & ready;
  assign adv = (state_q == RUN) & en & ~clr & ~at_end;
  assign fin = (state_q == RUN) & en & ~clr & at_end & ~accept;

  // |x| fits DATA_WIDTH unsigned even for the most negative value
  assign neg   = i_data[DATA_WIDTH-1];
  assign abs_v = neg ? (~i_data + DATA_WIDTH'(1)) : i_data;
  assign abs_w = AW'(abs_v);
  assign sat   = (abs_w > AW'(CNT_MAX)) ?
                 CNT_MAX : abs_w[CNT_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    dff_d   = dff_q;
    osign_d = osign_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    cnt_ld0 = 1'b0;
    unique case (1'b1)
      clr: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        osign_d = 1'b0;
        dff_d   = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
      accept: begin
        state_d = RUN;
        sign_d  = neg;
        mag_d   = sat;
        cnt_ld0 = 1'b1;
        osign_d = neg;
        busy_d  = 1'b1;
        dff_d   = sat > rev_d;
        last_d  = 1'b0;
      end
      fin: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        osign_d = 1'b0;
        dff_d   = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
      adv: begin
        cnt_en = 1'b1;
        dff_d  = mag_q > rev_d;
        last_d = (cnt == (CNT_MAX - CNT_WIDTH'(1)));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      dff_q   <= 1'b0;
      osign_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      dff_q   <= dff_d;
      osign_q <= osign_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      alive_q <= 1'b1;
    end
  end

  assign o_ready     = ready;
  assign o_data_sign = osign_q;
  assign o_data_dff  = dff_q;
  assign o_busy      = busy_q;
  assign o_last      = last_q;

endmodule

// File: tb/tb_unary_rate_gen.sv
// Scoreboard bench for unary_rate_gen: stimulus pushes whole expected
// streams, a negedge monitor compares and pops each consumed bit.
module tb_unary_rate_gen;
  localparam int DW = 8;
  localparam int CW = 7;
  localparam int N  = 1 << CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic o_ready, o_data_sign, o_data_dff, o_busy, o_last;

  unary_rate_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_data_sign (o_data_sign),
    .o_data_dff  (o_data_dff),
    .o_busy      (o_busy),
    .o_last      (o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sign;
    bit dff;
    bit last;
    bit first;
    int mag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  bit en_rand = 1'b0;
  int ones = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int bitrev(int k);
    int r = 0;
    for (int b = 0; b < CW; b++)
      if (k[b]) r = r | (1 << (CW - 1 - b));
    return r;
  endfunction

  function automatic int ref_mag(int v);
    int m = (v < 0) ? -v : v;
    if (m > N - 1) m = N - 1;
    return m;
  endfunction

  // One full expected stream for operand v
  task automatic push_stream(int v);
    exp_t e;
    int m = ref_mag(v);
    for (int k = 0; k < N; k++) begin
      e.sign  = (v < 0);
      e.dff   = (bitrev(k) < m);
      e.last  = (k == N - 1);
      e.first = (k == 0);
      e.mag   = m;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    en = en_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      bit exp_rdy;
      exp_rdy = !clr && (q.size() == 0 || (q.size() == 1 && en));
      chk("ready", {31'b0, o_ready}, {31'b0, exp_rdy});
      if (q.size() == 0) begin
        chk("idle_busy", {31'b0, o_busy}, 0);
        chk("idle_bits", {29'b0, o_data_sign, o_data_dff, o_last}, 0);
      end else begin
        e = q[0];
        chk("busy", {31'b0, o_busy}, 1);
        chk("sign", {31'b0, o_data_sign}, {31'b0, e.sign});
        chk("dff", {31'b0, o_data_dff}, {31'b0, e.dff});
        chk("last", {31'b0, o_last}, {31'b0, e.last});
        if (en && !clr) begin
          void'(q.pop_front());
          if (e.first) ones = 0;
          ones += int'(e.dff);
          if (e.last) chk("ones", ones, e.mag);
        end
      end
    end
  end

  task automatic load(int v);
    int t = 0;
    bit got = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_data  = DW'(v);
    while (!got && t < 2000) begin
      @(negedge clk);
      if (o_ready) got = 1'b1;
      else t++;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = DW'($urandom);
    if (got) begin
      push_stream(v);
    end else begin
      errors++;
      $display("FAIL accept_timeout: operand %0d never accepted", v);
    end
  endtask

  task automatic wait_left(int left);
    int t = 0;
    while (q.size() > left && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (q.size() > left) begin
      errors++;
      $display("FAIL drain_timeout: %0d left, want %0d", q.size(), left);
    end
  endtask

  task automatic wait_idle();
    wait_left(0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, {31'b0, o_busy}, 0);
    chk({tag, "_bits"}, {29'b0, o_data_sign, o_data_dff, o_last}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] r;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    chk("rst_ready", {31'b0, o_ready}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    load(64);
    wait_idle();
    load(-128);
    load(-1);
    wait_idle();
    load(0);
    wait_idle();
    load(127);
    wait_idle();

    en_rand = 1'b1;
    load(37);
    wait_idle();
    en_rand = 1'b0;

    load(100);
    wait_left(N - 50);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    q.delete();
    load(-5);
    wait_idle();

    load(100);
    wait_left(N - 50);
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    chk("arst_ready", {31'b0, o_ready}, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    load(3);
    wait_idle();

    en_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r = DW'($urandom);
      load(int'($signed(r)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    en_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
